cdc_hs_src_ctrl: RTL and testbench

Source-side controller for a four-phase req/ack handshake that moves a multi-bit word across a clock-domain boundary. It captures a word from a valid/ready producer, holds it stable on `hs_data`, and sequences `hs_req` against `hs_ack_sync`. `hs_ack_sync` is the destination's ack, already passed through an external `ff_sync` instance clocked by `clk_a`. The block runs entirely in the source domain and carries a sticky timeout monitor for a stalled far side.

---
 rtl/cdc_hs_pkg.sv | 13 +
 rtl/cdc_hs_timer.sv | 38 +++
 rtl/cdc_hs_src_ctrl.sv | 88 ++++++++
 tb/tb_cdc_hs_src_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// rtl/cdc_hs_pkg.sv - shared definitions for the req/ack handshake controllers
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_REL  = 2'd2
  } hs_state_e;

  localparam int unsigned HS_DATA_W  = 8;
  localparam int unsigned HS_TIMEOUT = 64;

endpackage

// File: rtl/cdc_hs_timer.sv
// rtl/cdc_hs_timer.sv - saturating per-phase cycle counter with terminal flag
module cdc_hs_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned    CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  T_MAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en && (cnt != T_MAX)) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Flag coincides with the counter landing on (or sitting at) the limit.
  assign hit = (cnt_nxt == T_MAX);

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// rtl/cdc_hs_src_ctrl.sv - source-side four-phase req/ack handshake controller
module cdc_hs_src_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_W  = HS_DATA_W,
  parameter int unsigned TIMEOUT = HS_TIMEOUT
) (
  input  logic              clk_a,
  input  logic              rst_a,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              hs_req,
  output logic [DATA_W-1:0] hs_data,
  input  logic              hs_ack_sync,
  output logic              done,
  output logic              busy,
  output logic              to_err,
  input  logic              err_clr
);

  localparam logic [1:0] ST_IDLE = HS_IDLE;
  localparam logic [1:0] ST_REQ  = HS_REQ;
  localparam logic [1:0] ST_REL  = HS_REL;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       accept;
  logic       timer_hit;

  // A stale high ack from the previous round must not let a new word in.
  assign in_ready = (state == ST_IDLE) && !hs_ack_sync;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)       state_nxt = ST_REQ;
      ST_REQ:  if (hs_ack_sync)  state_nxt = ST_REL;
      ST_REL:  if (!hs_ack_sync) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      state   <= ST_IDLE;
      hs_req  <= 1'b0;
      hs_data <= '0;
      done    <= 1'b0;
    end else begin
      state  <= state_nxt;
      hs_req <= (state_nxt == ST_REQ);
      if (accept) begin
        hs_data <= in_data;
      end
      done <= (state == ST_REL) && !hs_ack_sync;
    end
  end

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      to_err <= 1'b0;
    end else if (timer_hit) begin
      to_err <= 1'b1;
    end else if (err_clr) begin
      to_err <= 1'b0;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timer
      cdc_hs_timer #(
        .TIMEOUT (TIMEOUT)
      ) u_timer (
        .clk (clk_a),
        .rst (rst_a),
        .clr ((state_nxt != state) || (state == ST_IDLE)),
        .en  (busy),
        .hit (timer_hit)
      );
    end else begin : g_no_timer
      assign timer_hit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// tb/tb_cdc_hs_src_ctrl.sv - self-checking bench for cdc_hs_src_ctrl
module tb_cdc_hs_src_ctrl;

  logic       clk_a = 1'b0;
  logic       rst_a;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       hs_req;
  logic [7:0] hs_data;
  logic       hs_ack_sync;
  logic       done;
  logic       busy;
  logic       to_err;
  logic       err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  // transaction-level reference state
  logic       m_inflight;
  logic       m_acked;
  logic       m_done;
  logic       m_err;
  logic [7:0] m_data;
  int         m_age;
  logic [7:0] sb_q[$];

  cdc_hs_src_ctrl #(
    .DATA_W  (8),
    .TIMEOUT (8)
  ) dut (
    .clk_a       (clk_a),
    .rst_a       (rst_a),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .hs_req      (hs_req),
    .hs_data     (hs_data),
    .hs_ack_sync (hs_ack_sync),
    .done        (done),
    .busy        (busy),
    .to_err      (to_err),
    .err_clr     (err_clr)
  );

  always #5 clk_a = ~clk_a;

  task automatic tick();
    @(posedge clk_a);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the reference across one edge using the protocol rules only.
  task automatic model_edge();
    logic phase_change;
    phase_change = 1'b0;
    m_done = 1'b0;
    if (!m_inflight) begin
      if (in_valid && !hs_ack_sync) begin
        m_inflight   = 1'b1;
        m_acked      = 1'b0;
        m_data       = in_data;
        sb_q.push_back(in_data);
        phase_change = 1'b1;
      end
    end else if (!m_acked) begin
      if (hs_ack_sync) begin
        m_acked      = 1'b1;
        phase_change = 1'b1;
      end
    end else if (!hs_ack_sync) begin
      m_inflight   = 1'b0;
      m_done       = 1'b1;
      phase_change = 1'b1;
    end
    if (phase_change || !m_inflight) m_age = 0;
    else if (m_age < 8)              m_age = m_age + 1;
    if (m_age == 8)   m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  logic [7:0] words[3];
  logic [7:0] got;
  int         done_cyc[$];
  logic [7:0] done_dat[$];
  int         n_acc;
  logic       acc_pending;

  initial begin
    rst_a       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    hs_ack_sync = 1'b0;
    err_clr     = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    #1;
    chk1("rst_req", hs_req, 1'b0);
    chk8("rst_data", hs_data, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_to_err", to_err, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);

    // single transfer with slow ack
    tick();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk1("single_req_rise", hs_req, 1'b1);
    chk1("single_busy", busy, 1'b1);
    chk1("single_not_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("single_req_hold", hs_req, 1'b1);
      chk8("single_data", hs_data, 8'hA5);
    end
    hs_ack_sync = 1'b1;
    tick();
    chk1("single_req_fall", hs_req, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("single_rel_nodone", done, 1'b0);
      chk8("single_rel_data", hs_data, 8'hA5);
    end
    hs_ack_sync = 1'b0;
    tick();
    chk1("single_done", done, 1'b1);
    chk8("single_done_data", hs_data, 8'hA5);
    tick();
    chk1("single_done_once", done, 1'b0);
    chk1("single_ready_after", in_ready, 1'b1);

    // back-to-back with ideal 1-cycle ack
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    n_acc    = 0;
    in_valid = 1'b1;
    in_data  = words[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) begin
        done_cyc.push_back(cyc);
        done_dat.push_back(hs_data);
      end
      hs_ack_sync = hs_req;
      #1;
      acc_pending = in_valid && in_ready;
      tick();
      if (acc_pending) begin
        n_acc++;
        if (n_acc < 3) in_data = words[n_acc];
        else           in_valid = 1'b0;
      end
    end
    hs_ack_sync = 1'b0;
    chk8("b2b_done_count", 8'(done_cyc.size()), 8'd3);
    for (int i = 0; i < done_dat.size() && i < 3; i++) begin
      chk8("b2b_order", done_dat[i], words[i]);
      if (i > 0) chk1("b2b_gap", (done_cyc[i] - done_cyc[i-1]) >= 3, 1'b1);
    end

    // stale ack blocks acceptance
    tick();
    in_valid    = 1'b1;
    in_data     = 8'h3C;
    hs_ack_sync = 1'b1;
    #1;
    chk1("stale_not_ready", in_ready, 1'b0);
    tick();
    chk1("stale_no_req", hs_req, 1'b0);
    chk1("stale_no_busy", busy, 1'b0);
    chk8("stale_no_capture", hs_data, 8'h03);
    hs_ack_sync = 1'b0;
    #1;
    chk1("stale_ready_after_drop", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk1("stale_capture_req", hs_req, 1'b1);
    chk8("stale_capture_data", hs_data, 8'h3C);
    hs_ack_sync = 1'b1;
    tick();
    hs_ack_sync = 1'b0;
    tick();
    chk1("stale_done", done, 1'b1);
    tick();

    // randomized traffic against the reference
    m_inflight = 1'b0;
    m_acked    = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
    m_age      = 0;
    m_data     = 8'h3C;
    for (int c = 0; c < 420; c++) begin
      chk1("rnd_req", hs_req, m_inflight && !m_acked);
      chk1("rnd_busy", busy, m_inflight);
      chk1("rnd_done", done, m_done);
      chk1("rnd_to_err", to_err, m_err);
      chk8("rnd_data", hs_data, m_data);
      if (m_done) begin
        got = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        chk8("rnd_sb_order", hs_data, got);
      end
      if (c < 400) begin
        in_valid = ($urandom_range(3) != 0);
        in_data  = 8'($urandom);
        if ($urandom_range(2) == 0) hs_ack_sync = ~hs_ack_sync;
        err_clr  = ($urandom_range(15) == 0);
      end else begin
        in_valid    = 1'b0;
        hs_ack_sync = m_inflight && !m_acked;
        err_clr     = 1'b0;
      end
      #1;
      chk1("rnd_in_ready", in_ready, !m_inflight && !hs_ack_sync);
      model_edge();
      tick();
    end
    chk1("rnd_drained", busy, 1'b0);

    // timeout with a stalled far side
    in_valid    = 1'b0;
    hs_ack_sync = 1'b0;
    err_clr     = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("to_cleared_idle", to_err, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk1("to_req", hs_req, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk1("to_not_yet", to_err, 1'b0);
    end
    tick();
    chk1("to_set", to_err, 1'b1);
    chk1("to_req_held", hs_req, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("to_set_wins", to_err, 1'b1);
    hs_ack_sync = 1'b1;
    tick();
    chk1("to_late_ack_req", hs_req, 1'b0);
    chk1("to_sticky", to_err, 1'b1);
    hs_ack_sync = 1'b0;
    tick();
    chk1("to_late_done", done, 1'b1);
    chk8("to_late_data", hs_data, 8'h5A);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("to_clr", to_err, 1'b0);

    // reset while releasing
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid    = 1'b0;
    hs_ack_sync = 1'b1;
    tick();
    chk1("mid_rel_req", hs_req, 1'b0);
    chk1("mid_rel_busy", busy, 1'b1);
    rst_a       = 1'b1;
    hs_ack_sync = 1'b0;
    tick();
    chk1("mid_rst_req", hs_req, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk8("mid_rst_data", hs_data, 8'h00);
    rst_a = 1'b0;
    tick();
    chk1("mid_after_done", done, 1'b0);
    chk1("mid_after_ready", in_ready, 1'b1);
    chk1("mid_after_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
